// File: rtl/fpga_board_ctrl.sv
// -----------------------------------------------------------------------------
// fpga_board_ctrl
//
// Board-level glue between raw FPGA pins and the SoC:
//   - two-flop synchronisers for every button pin and the UART RX pin
//   - per-button debouncer producing a clean active-high level plus a
//     one-cycle press pulse
//   - SoC reset stretcher (HOLD/RUN FSM); an optional button re-enters HOLD
//   - LED driver: heartbeat on LED0 while the SoC is held in reset, SoC LEDs
//     while it runs; pin polarity selected by parameter
//
// Ports
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   buttons_i       raw button pins (asynchronous)
//   uart_rx_i       raw UART RX pin (asynchronous)
//   uart_rx_o       synchronised UART RX towards the SoC
//   soc_rst_n       registered active-low SoC reset
//   buttons_o       debounced button levels, 1 = pressed
//   button_press_o  one-cycle pulse when a debounced level rises
//   soc_leds_i      SoC LED requests, 1 = lit
//   led_o           registered LED pins, polarity per LED_ACTIVE_LOW
// -----------------------------------------------------------------------------
module fpga_board_ctrl #(
  parameter int NUM_BUTTONS       = 2,
  parameter int LEDS_WIDTH        = 6,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int RESET_HOLD_CYCLES = 1024,
  parameter int HEARTBEAT_CYCLES  = 12500000,
  parameter int BUTTON_ACTIVE_LOW = 1,
  parameter int LED_ACTIVE_LOW    = 1,
  parameter int SOFT_RST_EN       = 1,
  parameter int SOFT_RST_BUTTON   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] buttons_i,
  input  logic                   uart_rx_i,
  output logic                   uart_rx_o,
  output logic                   soc_rst_n,
  output logic [NUM_BUTTONS-1:0] buttons_o,
  output logic [NUM_BUTTONS-1:0] button_press_o,
  input  logic [LEDS_WIDTH-1:0]  soc_leds_i,
  output logic [LEDS_WIDTH-1:0]  led_o
);

  // Parameter range checks at elaboration time
  if (NUM_BUTTONS < 1) begin : g_err_nb
    $error("NUM_BUTTONS must be >= 1");
  end
  if (LEDS_WIDTH < 1) begin : g_err_lw
    $error("LEDS_WIDTH must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_err_db
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (RESET_HOLD_CYCLES < 1) begin : g_err_rh
    $error("RESET_HOLD_CYCLES must be >= 1");
  end
  if (HEARTBEAT_CYCLES < 1) begin : g_err_hb
    $error("HEARTBEAT_CYCLES must be >= 1");
  end
  if ((BUTTON_ACTIVE_LOW != 0) && (BUTTON_ACTIVE_LOW != 1)) begin : g_err_bal
    $error("BUTTON_ACTIVE_LOW must be 0 or 1");
  end
  if ((LED_ACTIVE_LOW != 0) && (LED_ACTIVE_LOW != 1)) begin : g_err_lal
    $error("LED_ACTIVE_LOW must be 0 or 1");
  end
  if ((SOFT_RST_EN != 0) && (SOFT_RST_EN != 1)) begin : g_err_sre
    $error("SOFT_RST_EN must be 0 or 1");
  end
  if ((SOFT_RST_BUTTON < 0) || (SOFT_RST_BUTTON >= NUM_BUTTONS)) begin : g_err_srb
    $error("SOFT_RST_BUTTON must be < NUM_BUTTONS");
  end

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int HB_W   = $clog2(HEARTBEAT_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HEARTBEAT_CYCLES - 1);
  localparam logic [HB_W-1:0]   HB_ONE    = HB_W'(1);

  // Pin level of a released button; XOR with it turns pin level into "pressed"
  localparam logic [NUM_BUTTONS-1:0] BTN_IDLE =
    (BUTTON_ACTIVE_LOW != 0) ? {NUM_BUTTONS{1'b1}} : {NUM_BUTTONS{1'b0}};
  // Pin level of an unlit LED; XOR with it turns "lit" into pin level
  localparam logic [LEDS_WIDTH-1:0] LED_OFF =
    (LED_ACTIVE_LOW != 0) ? {LEDS_WIDTH{1'b1}} : {LEDS_WIDTH{1'b0}};

  typedef enum logic [0:0] {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [NUM_BUTTONS-1:0] btn_meta_r;
  logic [NUM_BUTTONS-1:0] btn_sync_r;
  logic                   rx_meta_r;
  logic                   rx_sync_r;
  logic [NUM_BUTTONS-1:0] btn_level_s;
  logic [DB_W-1:0]        db_cnt_r [NUM_BUTTONS];
  state_t                 state_r;
  state_t                 state_s;
  logic [HOLD_W-1:0]      hold_cnt_r;
  logic [HOLD_W-1:0]      hold_cnt_s;
  logic                   soft_press_s;
  logic [HB_W-1:0]        hb_cnt_r;
  logic                   hb_r;
  logic [LEDS_WIDTH-1:0]  led_lit_s;

  // Two-flop synchronisers; reset to the idle pin levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_r <= BTN_IDLE;
      btn_sync_r <= BTN_IDLE;
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
    end else begin
      btn_meta_r <= buttons_i;
      btn_sync_r <= btn_meta_r;
      rx_meta_r  <= uart_rx_i;
      rx_sync_r  <= rx_meta_r;
    end
  end

  assign uart_rx_o   = rx_sync_r;
  assign btn_level_s = btn_sync_r ^ BTN_IDLE;

  // Debouncers: a level differing from the accepted one must persist for
  // DEBOUNCE_CYCLES consecutive edges; press pulses only on acceptance of a 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buttons_o      <= {NUM_BUTTONS{1'b0}};
      button_press_o <= {NUM_BUTTONS{1'b0}};
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        db_cnt_r[i] <= {DB_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        button_press_o[i] <= 1'b0;
        if (btn_level_s[i] == buttons_o[i]) begin
          db_cnt_r[i] <= {DB_W{1'b0}};
        end else if (db_cnt_r[i] == DB_LAST) begin
          buttons_o[i]      <= btn_level_s[i];
          button_press_o[i] <= btn_level_s[i];
          db_cnt_r[i]       <= {DB_W{1'b0}};
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
        end
      end
    end
  end

  assign soft_press_s = (SOFT_RST_EN != 0) && button_press_o[SOFT_RST_BUTTON];

  // Reset FSM next state; a soft-reset press always restarts the hold window
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    case (state_r)
      ST_HOLD: begin
        if (soft_press_s) begin
          hold_cnt_s = {HOLD_W{1'b0}};
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_s    = ST_RUN;
          hold_cnt_s = {HOLD_W{1'b0}};
        end else begin
          hold_cnt_s = hold_cnt_r + HOLD_ONE;
        end
      end
      ST_RUN: begin
        if (soft_press_s) begin
          state_s    = ST_HOLD;
          hold_cnt_s = {HOLD_W{1'b0}};
        end else begin
          state_s    = ST_RUN;
        end
      end
      default: begin
        state_s    = ST_HOLD;
        hold_cnt_s = {HOLD_W{1'b0}};
      end
    endcase
  end

  // Reset FSM state register; soc_rst_n is registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_HOLD;
      hold_cnt_r <= {HOLD_W{1'b0}};
      soc_rst_n  <= 1'b0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      soc_rst_n  <= (state_s == ST_RUN);
    end
  end

  // Free-running heartbeat: hb toggles every HEARTBEAT_CYCLES edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt_r <= {HB_W{1'b0}};
      hb_r     <= 1'b0;
    end else if (hb_cnt_r == HB_LAST) begin
      hb_cnt_r <= {HB_W{1'b0}};
      hb_r     <= ~hb_r;
    end else begin
      hb_cnt_r <= hb_cnt_r + HB_ONE;
    end
  end

  // LED pattern in "lit" terms: heartbeat on LED0 while held, SoC LEDs in RUN
  always_comb begin
    led_lit_s = {LEDS_WIDTH{1'b0}};
    if (state_r == ST_RUN) begin
      led_lit_s = soc_leds_i;
    end else begin
      led_lit_s[0] = hb_r;
    end
  end

  // LED pin register with polarity applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_o <= LED_OFF;
    end else begin
      led_o <= led_lit_s ^ LED_OFF;
    end
  end

endmodule

// File: tb/tb_fpga_board_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpga_board_ctrl
//
// Scoreboard bench: a behavioural model, stepped on every rising edge, pushes
// the expected outputs into a queue; a monitor on the falling edge pops and
// compares. The model works from edge numbers since reset release: hb is
// (n / HB) % 2, the SoC runs once n >= hold_start + H, and a button level is
// accepted once its synced value has disagreed for D edges in a row.
// -----------------------------------------------------------------------------
module tb_fpga_board_ctrl;

  localparam int NB = 2;
  localparam int LW = 6;
  localparam int D  = 8;
  localparam int H  = 16;
  localparam int HB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] buttons_i;
  logic          uart_rx_i;
  logic          uart_rx_o;
  logic          soc_rst_n;
  logic [NB-1:0] buttons_o;
  logic [NB-1:0] button_press_o;
  logic [LW-1:0] soc_leds_i;
  logic [LW-1:0] led_o;

  fpga_board_ctrl #(
    .NUM_BUTTONS(NB), .LEDS_WIDTH(LW), .DEBOUNCE_CYCLES(D),
    .RESET_HOLD_CYCLES(H), .HEARTBEAT_CYCLES(HB), .BUTTON_ACTIVE_LOW(1),
    .LED_ACTIVE_LOW(1), .SOFT_RST_EN(1), .SOFT_RST_BUTTON(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .buttons_i(buttons_i), .uart_rx_i(uart_rx_i),
    .uart_rx_o(uart_rx_o), .soc_rst_n(soc_rst_n), .buttons_o(buttons_o),
    .button_press_o(button_press_o), .soc_leds_i(soc_leds_i), .led_o(led_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          uart;
    logic          soc;
    logic [NB-1:0] btn;
    logic [NB-1:0] press;
    logic [LW-1:0] led;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.uart  = 1'b1;
    e.soc   = 1'b0;
    e.btn   = '0;
    e.press = '0;
    e.led   = {LW{1'b1}};
    return e;
  endfunction

  // ---------------- reference model ----------------
  int            n;
  int            hold_start;
  int            t_eq [NB];
  logic [NB-1:0] level;
  logic [NB-1:0] pin_d1, pin_d2;
  logic          rx_d1, rx_d2;
  logic          prev_run, prev_hb;
  logic [NB-1:0] prev_press;

  task automatic model_reset();
    n = 0; hold_start = 0; level = '0;
    for (int i = 0; i < NB; i++) t_eq[i] = 0;
    pin_d1 = '1; pin_d2 = '1; rx_d1 = 1'b1; rx_d2 = 1'b1;
    prev_run = 1'b0; prev_hb = 1'b0; prev_press = '0;
  endtask

  initial model_reset();

  // Stale expectations die with an asynchronous reset
  always @(negedge rst_n) exp_q.delete();

  always @(posedge clk) begin
    exp_t          e;
    logic [NB-1:0] seen;
    logic [NB-1:0] press;
    logic          run, hb;
    if (!rst_n) begin
      model_reset();
      exp_q.push_back(reset_exp());
    end else begin
      n++;
      seen  = ~pin_d2;                 // pressed-level visible to this edge
      pin_d2 = pin_d1; pin_d1 = buttons_i;
      rx_d2  = rx_d1;  rx_d1  = uart_rx_i;
      press = '0;
      for (int i = 0; i < NB; i++) begin
        if (seen[i] == level[i]) t_eq[i] = n;
        else if (n - t_eq[i] >= D) begin
          level[i] = seen[i];
          press[i] = seen[i];
          t_eq[i]  = n;
        end
      end
      if (prev_press[0]) hold_start = n;
      run = (n >= hold_start + H);
      hb  = ((n / HB) % 2) == 1;
      e.uart  = rx_d2;
      e.soc   = run;
      e.btn   = level;
      e.press = press;
      e.led   = prev_run ? ~soc_leds_i : ~{{(LW-1){1'b0}}, prev_hb};
      exp_q.push_back(e);
      prev_run = run; prev_hb = hb; prev_press = press;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("uart_rx_o", 32'(uart_rx_o), 32'(e.uart));
      chk("soc_rst_n", 32'(soc_rst_n), 32'(e.soc));
      chk("buttons_o", 32'(buttons_o), 32'(e.btn));
      chk("button_press_o", 32'(button_press_o), 32'(e.press));
      chk("led_o", 32'(led_o), 32'(e.led));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int k, input bit rand_io);
    for (int c = 0; c < k; c++) begin
      @(negedge clk);
      if (rand_io) begin
        soc_leds_i = LW'($urandom);
        if ($urandom_range(0, 3) == 0) uart_rx_i = ~uart_rx_i;
      end
    end
  endtask

  task automatic check_reset_now(input string tag);
    #1;
    chk({tag, "_uart"},  32'(uart_rx_o), 32'(1));
    chk({tag, "_soc"},   32'(soc_rst_n), 32'(0));
    chk({tag, "_btn"},   32'(buttons_o), 32'(0));
    chk({tag, "_press"}, 32'(button_press_o), 32'(0));
    chk({tag, "_led"},   32'(led_o), 32'({LW{1'b1}}));
  endtask

  int rem [NB];

  initial begin
    rst_n = 1'b0; buttons_i = '1; uart_rx_i = 1'b1; soc_leds_i = 6'h05;
    repeat (3) @(negedge clk);
    check_reset_now("por");
    #2 rst_n = 1'b1;
    // Hold window, heartbeat, then SoC LEDs (6'h05 -> pins 6'h3A)
    cycles(24, 1'b0);
    cycles(16, 1'b1);
    // Short glitch on button 1 is ignored
    buttons_i[1] = 1'b0; cycles(5, 1'b0); buttons_i[1] = 1'b1; cycles(15, 1'b0);
    // Long press on button 1: accepted, no soft reset
    buttons_i[1] = 1'b0; cycles(20, 1'b1); buttons_i[1] = 1'b1; cycles(20, 1'b1);
    // Soft reset via button 0
    buttons_i[0] = 1'b0; cycles(12, 1'b0); buttons_i[0] = 1'b1; cycles(40, 1'b1);
    // Randomised button activity
    for (int i = 0; i < NB; i++) rem[i] = $urandom_range(1, 24);
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NB; i++) begin
        rem[i]--;
        if (rem[i] == 0) begin
          buttons_i[i] = ~buttons_i[i];
          rem[i] = $urandom_range(1, 24);
        end
      end
      cycles(1, 1'b1);
    end
    buttons_i = '1; cycles(40, 1'b1);
    // Reset in the middle of a debounce
    buttons_i[1] = 1'b0; cycles(5, 1'b0);
    #2 rst_n = 1'b0;
    check_reset_now("mid_db");
    buttons_i = '1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); uart_rx_i = ~uart_rx_i;
    end
    uart_rx_i = 1'b1;
    #2 rst_n = 1'b1;
    cycles(8, 1'b1);
    // Reset in the middle of HOLD
    #2 rst_n = 1'b0;
    check_reset_now("mid_hold");
    cycles(3, 1'b0);
    #2 rst_n = 1'b1;
    cycles(40, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
